// File: rtl/icu_pkg.sv
// Shared constants and state encoding for the interrupt controller.
package icu_pkg;

  localparam int N_IRQ_DEF      = 6;
  localparam int CAUSE_BASE_DEF = 16;
  localparam int MCAUSE_INT_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2,
    ST_EXIT    = 2'd3
  } icu_state_e;

endpackage

// File: rtl/icu_arbiter.sv
// Combinational winner selection over enabled pending requests.
// Macro ICU_RR_ARB_EN selects round-robin; otherwise fixed lowest-index priority.
module icu_arbiter
  import icu_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

`ifdef ICU_RR_ARB_EN
  // Walk the ring starting at rr_ptr; the first hit wins.
  always_comb begin
    int idx;
    valid = 1'b0;
    id    = '0;
    idx   = 0;
    for (int k = 0; k < N_IRQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_IRQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        id    = ID_W'(idx);
      end
    end
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // Scan downwards so the lowest set index is the last assignment.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: edge capture, masking, arbitration and trap entry/exit sequencing.
// Arbitration policy chosen by ICU_RR_ARB_EN in icu_arbiter.
//
// state   | meaning
// IDLE    | waiting for an enabled pending request while core_rdy is high
// ENTER   | trap entry cycle: int_o, en_mepc strobes; mepc/mcause written
// HANDLER | handler running; only mret advances, new edges just pend
// EXIT    | int_rst pulse to serviced source; its pending bit clears
module int_controller
  import icu_pkg::*;
#(
  parameter int N_IRQ      = N_IRQ_DEF,
  parameter int CAUSE_BASE = CAUSE_BASE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] int_i,
  input  logic [N_IRQ-1:0] mie,
  input  logic             core_rdy,
  input  logic             mret,
  input  logic [31:0]      pc,
  output logic             int_o,
  output logic             en_mepc,
  output logic [31:0]      mepc_csr,
  output logic [31:0]      mcause,
  output logic [N_IRQ-1:0] int_rst,
  output logic             busy
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  icu_state_e       state;
  logic [N_IRQ-1:0] int_q;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr_mask;
  logic [ID_W-1:0]  id;
  logic [ID_W-1:0]  rr_ptr;
  logic             arb_valid;
  logic [ID_W-1:0]  arb_id;
  logic [30:0]      cause_code;

  assign rise       = int_i & ~int_q;
  assign clr_mask   = (state == ST_EXIT) ? (N_IRQ'(1) << id) : '0;
  assign cause_code = 31'(CAUSE_BASE) + 31'(arb_id);

  icu_arbiter #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_arbiter (
    .req    (pend & mie),
    .rr_ptr (rr_ptr),
    .valid  (arb_valid),
    .id     (arb_id)
  );

  // A fresh edge in the EXIT cycle survives the clear of the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_q <= '0;
      pend  <= '0;
    end else begin
      int_q <= int_i;
      pend  <= (pend & ~clr_mask) | rise;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      id       <= '0;
      rr_ptr   <= '0;
      int_o    <= 1'b0;
      en_mepc  <= 1'b0;
      mepc_csr <= '0;
      mcause   <= '0;
      int_rst  <= '0;
      busy     <= 1'b0;
    end else begin
      int_o   <= 1'b0;
      en_mepc <= 1'b0;
      int_rst <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_valid && core_rdy) begin
            state    <= ST_ENTER;
            id       <= arb_id;
            int_o    <= 1'b1;
            en_mepc  <= 1'b1;
            mepc_csr <= pc;
            mcause   <= {1'b1, cause_code};
            busy     <= 1'b1;
          end
        end
        ST_ENTER: begin
          state  <= ST_HANDLER;
          rr_ptr <= (int'(id) == N_IRQ - 1) ? '0 : id + 1'b1;
        end
        ST_HANDLER: begin
          if (mret) begin
            state   <= ST_EXIT;
            int_rst <= N_IRQ'(1) << id;
            busy    <= 1'b0;
          end
        end
        ST_EXIT: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller; expectations follow the build's ICU_RR_ARB_EN setting.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic [5:0]  mie;
  logic        core_rdy;
  logic        mret;
  logic [31:0] pc;
  logic        int_o;
  logic        en_mepc;
  logic [31:0] mepc_csr;
  logic [31:0] mcause;
  logic [5:0]  int_rst;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  int_controller u_dut (
    .clk      (clk),
    .rst      (rst),
    .int_i    (int_i),
    .mie      (mie),
    .core_rdy (core_rdy),
    .mret     (mret),
    .pc       (pc),
    .int_o    (int_o),
    .en_mepc  (en_mepc),
    .mepc_csr (mepc_csr),
    .mcause   (mcause),
    .int_rst  (int_rst),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse mret from HANDLER, check the acknowledge and the return to IDLE.
  task automatic do_mret(input string tag, input logic [5:0] exp_ack);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check({tag, "_int_rst"}, 32'(int_rst), 32'(exp_ack));
    check({tag, "_busy_exit"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_int_rst_gone"}, 32'(int_rst), 32'd0);
  endtask

  logic [31:0] first_cause;
  logic [5:0]  first_ack;
  logic [31:0] second_cause;
  logic [5:0]  second_ack;

  initial begin
`ifdef ICU_RR_ARB_EN
    first_cause  = 32'h8000_0013;
    first_ack    = 6'b001000;
    second_cause = 32'h8000_0010;
    second_ack   = 6'b000001;
`else
    first_cause  = 32'h8000_0010;
    first_ack    = 6'b000001;
    second_cause = 32'h8000_0013;
    second_ack   = 6'b001000;
`endif
    rst = 1'b1; int_i = '0; mie = '0; core_rdy = 1'b0; mret = 1'b0; pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_int_o", 32'(int_o), 32'd0);
    check("rst_en_mepc", 32'(en_mepc), 32'd0);
    check("rst_mepc", mepc_csr, 32'd0);
    check("rst_mcause", mcause, 32'd0);
    check("rst_int_rst", 32'(int_rst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Basic trap on line 2
    mie = 6'b000100; core_rdy = 1'b1; pc = 32'h100;
    int_i = 6'b000100;
    tick();
    check("t2_int_o_n1", 32'(int_o), 32'd0);
    tick();
    check("t2_int_o", 32'(int_o), 32'd1);
    check("t2_en_mepc", 32'(en_mepc), 32'd1);
    check("t2_mepc", mepc_csr, 32'h100);
    check("t2_mcause", mcause, 32'h8000_0012);
    check("t2_busy", 32'(busy), 32'd1);
    tick();
    check("t2_int_o_pulse", 32'(int_o), 32'd0);
    check("t2_busy_handler", 32'(busy), 32'd1);
    int_i = '0;
    do_mret("t2", 6'b000100);
    check("t2_mcause_held", mcause, 32'h8000_0012);

    // Masked edge stays pending until mie rises
    mie = '0; int_i = 6'b000010;
    repeat (3) begin
      tick();
      check("t3_masked", 32'(int_o), 32'd0);
    end
    mie = 6'b000010;
    tick();
    check("t3_int_o", 32'(int_o), 32'd1);
    check("t3_mcause", mcause, 32'h8000_0011);
    tick();
    int_i = '0;
    do_mret("t3", 6'b000010);

    // Service id 0 first so a round-robin pointer sits at 1
    mie = 6'h3F; int_i = 6'b000001;
    tick(); tick();
    check("t4a_mcause", mcause, 32'h8000_0010);
    int_i = '0;
    tick();
    do_mret("t4a", 6'b000001);
    int_i = 6'b001001;
    tick(); tick();
    check("t4_first_int_o", 32'(int_o), 32'd1);
    check("t4_first_mcause", mcause, first_cause);
    int_i = '0;
    tick();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("t4_first_ack", 32'(int_rst), 32'(first_ack));
    tick();
    check("t4_gap", 32'(int_o), 32'd0);
    tick();
    check("t4_second_int_o", 32'(int_o), 32'd1);
    check("t4_second_mcause", mcause, second_cause);
    tick();
    do_mret("t4b", second_ack);

    // No nesting: edge during HANDLER waits for mret
    int_i = 6'b000100;
    tick(); tick();
    check("t5_mcause", mcause, 32'h8000_0012);
    tick();
    int_i = 6'b000110;
    repeat (3) begin
      tick();
      check("t5_no_nest", 32'(int_o), 32'd0);
      check("t5_busy", 32'(busy), 32'd1);
    end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("t5_ack", 32'(int_rst), 32'b000100);
    tick();
    check("t5_gap", 32'(int_o), 32'd0);
    tick();
    check("t5_reenter", 32'(int_o), 32'd1);
    check("t5_reenter_mcause", mcause, 32'h8000_0011);
    tick();

    // Reset while in HANDLER with another source pending
    int_i = 6'b010000;
    tick(); tick();
    int_i = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_mcause", mcause, 32'd0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("t6_no_ack", 32'(int_rst), 32'd0);
    repeat (3) begin
      tick();
      check("t6_pend_lost", 32'(int_o), 32'd0);
    end

    // core_rdy low holds IDLE; pending re-evaluated once it rises
    core_rdy = 1'b0; int_i = 6'b100000;
    repeat (3) begin
      tick();
      check("t7_hold", 32'(int_o), 32'd0);
    end
    core_rdy = 1'b1;
    tick();
    check("t7_int_o", 32'(int_o), 32'd1);
    check("t7_mcause", mcause, 32'h8000_0015);
    int_i = '0;
    tick();

    // New edge on the serviced line during EXIT keeps it pending
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("t8_ack", 32'(int_rst), 32'b100000);
    int_i = 6'b100000;
    tick();
    check("t8_gap", 32'(int_o), 32'd0);
    tick();
    check("t8_set_wins", 32'(int_o), 32'd1);
    check("t8_mcause", mcause, 32'h8000_0015);
    int_i = '0;
    tick();
    do_mret("t8", 6'b100000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
